// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states, stage shadows.
// No timing of its own; pure type and constant definitions.
package pipe_ctrl_pkg;

  // Shadow register fields are stored at this width; the top zero-extends REG_AW into it,
  // so REG_AW must not exceed SH_AW.
  localparam int SH_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } ctrl_state_t;

  typedef struct packed {
    logic             valid;
    logic [SH_AW-1:0] rd;
    logic [SH_AW-1:0] rs1;
    logic [SH_AW-1:0] rs2;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } stage_sh_t;

  // A writing stage supplies src only for a nonzero destination; x0 never matches.
  function automatic logic dst_hit(input logic valid, input logic wr,
                                   input logic [SH_AW-1:0] rd,
                                   input logic [SH_AW-1:0] src);
    return valid & wr & (rd != '0) & (rd == src);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational EX-operand forwarding and ID register-file bypass compares; zero latency.
// No backpressure; outputs follow the shadow fields and ID sources directly.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [SH_AW-1:0] mem_rd,
  input  logic             wb_valid,
  input  logic             wb_reg_write,
  input  logic [SH_AW-1:0] wb_rd,
  input  logic [SH_AW-1:0] ex_rs1,
  input  logic [SH_AW-1:0] ex_rs2,
  input  logic [SH_AW-1:0] id_rs1,
  input  logic [SH_AW-1:0] id_rs2,
  output fwd_sel_t         srca,
  output fwd_sel_t         srcb,
  output logic             bypass_a,
  output logic             bypass_b
);

  always_comb begin
    srca = FWD_RF;
    srcb = FWD_RF;
    // The younger producer in MEM shadows an older one in WB for the same register.
    if (dst_hit(mem_valid, mem_reg_write, mem_rd, ex_rs1))     srca = FWD_EXMEM;
    else if (dst_hit(wb_valid, wb_reg_write, wb_rd, ex_rs1))   srca = FWD_MEMWB;
    if (dst_hit(mem_valid, mem_reg_write, mem_rd, ex_rs2))     srcb = FWD_EXMEM;
    else if (dst_hit(wb_valid, wb_reg_write, wb_rd, ex_rs2))   srcb = FWD_MEMWB;
  end

  assign bypass_a = dst_hit(wb_valid, wb_reg_write, wb_rd, id_rs1);
  assign bypass_b = dst_hit(wb_valid, wb_reg_write, wb_rd, id_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard/sequencing control with forwarding, load-use bubble and branch squash; zero-cycle latency.
// Freezes every stage while the MEM-stage data access is not ready; a wait past MEM_TIMEOUT latches ERROR until reset.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              ex_branch_taken,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              mem_wb_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        alu_srca_fwd,
  output logic [1:0]        alu_srcb_fwd,
  output logic              rf_bypass_a,
  output logic              rf_bypass_b,
  output logic              load_use_stall,
  output logic              mem_timeout_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t     state_q, state_d;
  logic [WCW-1:0]  wait_cnt;
  logic [CNT_W-1:0] stall_q;
  stage_sh_t       id_sh, ex_sh, mem_sh, wb_sh;
  logic            freeze, load_use;
  fwd_sel_t        fwd_a, fwd_b;
  logic            byp_a, byp_b;

  always_comb begin
    id_sh           = '0;
    id_sh.valid     = id_valid;
    id_sh.rd        = SH_AW'(id_rd);
    id_sh.rs1       = SH_AW'(id_rs1);
    id_sh.rs2       = SH_AW'(id_rs2);
    id_sh.uses_rs1  = id_uses_rs1;
    id_sh.uses_rs2  = id_uses_rs2;
    id_sh.reg_write = id_reg_write;
    id_sh.mem_read  = id_mem_read;
    id_sh.mem_write = id_mem_write;
  end

  assign freeze = mem_sh.valid & (mem_sh.mem_read | mem_sh.mem_write) & ~dmem_ready;

  assign load_use = ex_sh.valid & ex_sh.mem_read & (ex_sh.rd != '0) & id_valid &
                    ((id_uses_rs1 & (ex_sh.rd == id_sh.rs1)) |
                     (id_uses_rs2 & (ex_sh.rd == id_sh.rs2)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (freeze) state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (dmem_ready)                                state_d = RUN;
        else if (wait_cnt == WCW'(MEM_TIMEOUT - 1))    state_d = ERROR;
      end
      ERROR:    state_d = ERROR;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    pc_write        = 1'b0;
    if_id_write     = 1'b0;
    id_ex_write     = 1'b0;
    ex_mem_write    = 1'b0;
    mem_wb_write    = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    load_use_stall  = 1'b0;
    mem_timeout_err = 1'b0;
    if (!rst_n) begin
      pc_write = 1'b0;
    end else if (state_q == ERROR) begin
      mem_timeout_err = 1'b1;
    end else if (freeze) begin
      pc_write = 1'b0;
    end else if (ex_branch_taken) begin
      // Squashing the ID instruction also removes any load-use dependency it carried.
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      id_ex_write    = 1'b1;
      ex_mem_write   = 1'b1;
      mem_wb_write   = 1'b1;
      id_ex_flush    = 1'b1;
      load_use_stall = 1'b1;
    end else begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '1;
    end
  end

  pipe_fwd_unit u_fwd (
    .mem_valid     (mem_sh.valid),
    .mem_reg_write (mem_sh.reg_write),
    .mem_rd        (mem_sh.rd),
    .wb_valid      (wb_sh.valid),
    .wb_reg_write  (wb_sh.reg_write),
    .wb_rd         (wb_sh.rd),
    .ex_rs1        (ex_sh.rs1),
    .ex_rs2        (ex_sh.rs2),
    .id_rs1        (id_sh.rs1),
    .id_rs2        (id_sh.rs2),
    .srca          (fwd_a),
    .srcb          (fwd_b),
    .bypass_a      (byp_a),
    .bypass_b      (byp_b)
  );

  assign alu_srca_fwd = rst_n ? fwd_a : FWD_RF;
  assign alu_srcb_fwd = rst_n ? fwd_b : FWD_RF;
  assign rf_bypass_a  = rst_n & byp_a;
  assign rf_bypass_b  = rst_n & byp_b;
  assign stall_cycles = stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && freeze) wait_cnt <= '0;
      else if (state_q == MEM_WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Shadows move exactly when the ID/EX register loads, so they track the real pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_sh  <= '0;
      mem_sh <= '0;
      wb_sh  <= '0;
    end else if (id_ex_write) begin
      ex_sh  <= id_ex_flush ? '0 : id_sh;
      mem_sh <= ex_sh;
      wb_sh  <= mem_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!pc_write && state_q != ERROR && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  // WB shadow fields kept for visibility but not needed by any compare.
  logic unused_wb;
  assign unused_wb = ^{wb_sh.rs1, wb_sh.rs2, wb_sh.uses_rs1, wb_sh.uses_rs2,
                       wb_sh.mem_read, wb_sh.mem_write};

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It keeps shadow copies of the destination and source register fields for the EX, MEM and WB stages. From these it drives:
- the PC and pipeline-register write enables;
- bubble and flush controls;
- the EX-stage forwarding selects and the ID-stage register-file bypass.

It also freezes the whole pipeline while a data-memory access is outstanding, and has a timeout watchdog and a stall-cycle counter.

## Interface
Parameters:
- REG_AW, 5, register address width.
- MEM_TIMEOUT, 255, maximum wait cycles for one memory access before the block enters ERROR.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock; one clock domain only.
- rst_n  in  1  reset; synchronous, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source registers of the ID-stage instruction.
- id_uses_rs1, id_uses_rs2  in  1  the ID-stage instruction reads that source.
- id_rd  in  REG_AW  destination register of the ID-stage instruction.
- id_reg_write, id_mem_read, id_mem_write  in  1  decoded ID-stage controls.
- ex_branch_taken  in  1  the EX-stage branch resolved as taken.
- dmem_ready  in  1  the data memory completes the MEM-stage access this cycle.
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1  register load enables.
- if_id_flush, id_ex_flush  out  1  load a bubble (all zeros) instead of the incoming value.
- alu_srca_fwd, alu_srcb_fwd  out  2  EX operand select.
  - 00: ID_EX register value.
  - 01: EX_MEM ALU result.
  - 10: MEM_WB write data.
- rf_bypass_a, rf_bypass_b  out  1  the ID stage takes the WB write data instead of the register-file read.
- load_use_stall  out  1  a load-use bubble is being inserted this cycle.
- mem_timeout_err  out  1  sticky error flag.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

## Operation
- Shadow registers ex_sh, mem_sh, wb_sh hold these fields: valid, rd, rs1, rs2, uses_rs1, uses_rs2, reg_write, mem_read, mem_write.
- Each non-frozen cycle the shadows advance:
  - ex_sh loads the ID fields, or all zeros if id_ex_flush is asserted.
  - mem_sh loads ex_sh.
  - wb_sh loads mem_sh.
- When frozen, all shadows hold their values.
- Register x0 (rd==0) never matches a source, never causes a hazard and never causes forwarding.
- freeze = mem_sh.valid & (mem_sh.mem_read | mem_sh.mem_write) & ~dmem_ready.
- The FSM has three states: RUN, MEM_WAIT, ERROR.
  - RUN goes to MEM_WAIT when freeze=1.
  - MEM_WAIT goes to RUN on dmem_ready=1.
  - MEM_WAIT goes to ERROR when the wait counter reaches MEM_TIMEOUT.
  - ERROR is left only by reset.
- The wait counter is cleared on entry to MEM_WAIT and increments on each MEM_WAIT cycle.
- Priority order, highest first: ERROR, freeze, branch, load-use.
  - ERROR: all enables and flushes 0, mem_timeout_err=1.
  - Freeze: all five enables 0, flushes 0. The shadows hold and ex_branch_taken is ignored; the branch re-asserts after the freeze because the branch instruction is still in EX.
  - Branch (ex_branch_taken=1): all enables 1, if_id_flush=1, id_ex_flush=1.
  - Load-use: ex_sh.valid & ex_sh.mem_read & rd≠0 & rd matches a used ID source & id_valid. Then pc_write=0, if_id_write=0, id_ex_flush=1, load_use_stall=1, and the other enables stay 1.
  - Otherwise all enables are 1 and all flushes 0.
- Forwarding, per operand, for the EX-stage instruction:
  - Select 01 if mem_sh.valid, mem_sh.reg_write, rd≠0 and rd equals the EX source.
  - Otherwise select 10 if wb_sh matches under the same conditions.
  - Otherwise select 00.
  - mem_sh matching a load cannot occur, because the load-use bubble prevents it.
- rf_bypass_a/b = wb_sh.valid & wb_sh.reg_write & rd≠0 & rd==id_rs1 (for _a) or id_rs2 (for _b).
- stall_cycles increments on each cycle with pc_write=0 outside ERROR, and saturates at all ones.

## Timing
- All control outputs are combinational from state, shadows and the current inputs, so there is zero-cycle latency.
- A load-use hazard costs exactly 1 bubble.
- A taken branch costs 2 squashed instructions.
- A memory wait of N cycles freezes the pipeline for N cycles.
- Reset behaviour:
  - While rst_n=0: all enables 0, flushes 0, fwd 00, bypass 0, load_use_stall 0, mem_timeout_err 0.
  - At the first rising edge with rst_n=0: shadows become invalid, the state becomes RUN, and the wait counter and stall_cycles become 0.
  - The cycle after rst_n rises: all enables are 1 (no hazards possible).
- Reset asserted in MEM_WAIT or ERROR returns the block to RUN at that edge and discards all shadow state.
- Simultaneous branch and load-use: the branch wins, and the dependent instruction is squashed.

## Structure
- Package pipe_ctrl_pkg holds:
  - the fwd_sel_t constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - the ctrl_state_t enum (RUN, MEM_WAIT, ERROR);
  - the stage_sh_t struct for the shadow fields.
- Sub-module pipe_fwd_unit holds the purely combinational source/destination compares (forwarding and bypass), instantiated once.

## Test plan
- Case 1: ADD x5 ← ..., then SUB using x5 in the next cycle.
  - Required: alu_srca_fwd=01 while SUB is in EX.
  - With one unrelated instruction between them: 10.
  - With two between: rf_bypass_a=1 in ID.
- Case 2: LW x7, then ADD using x7 as rs2.
  - Required: exactly one cycle with load_use_stall=1, pc_write=0, id_ex_flush=1.
  - Next cycle: alu_srcb_fwd=10.
  - stall_cycles=1.
- Case 3: rd=x0 producer followed by a consumer of x0.
  - Required: fwd stays 00 and there is no stall.
- Case 4: ex_branch_taken=1 together with a load-use condition.
  - Required: both flushes 1, pc_write=1, load_use_stall=0.
- Case 5: a store in MEM with dmem_ready low for 3 cycles.
  - Required: all enables 0 for 3 cycles, shadows unchanged, RUN resumes on the 4th cycle.
  - stall_cycles=3.
- Case 6: dmem_ready held low with MEM_TIMEOUT=4.
  - Required: ERROR entered and mem_timeout_err=1, sticky.
  - rst_n=0 for one edge clears it, with all enables 1 after release.
